pipeline_hazard_ctrl: RTL and testbench

Parametrised pipeline control unit for the ARM core that merges hazard detection and forwarding into one block. It keeps a registered scoreboard of in-flight writebacks, one entry per post-ID stage, and uses it to drive the stall, flush, freeze and per-source forwarding selects. It also keeps a saturating stall-cycle counter. It sits at the core top level between ID and the EXE/MEM/WB stages, driven by the stage-register outputs and the memory-ready signal.

---
 rtl/pipeline_ctrl_pkg.sv | 20 ++
 rtl/hazard_scoreboard.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 99 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and helpers for the pipeline hazard/forwarding control
package pipeline_ctrl_pkg;

    // Widest register address the scoreboard entry can hold; REG_ADDR_W must not exceed it.
    localparam int SB_ADDR_W_MAX = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                     valid;
        logic                     wb_en;
        logic [SB_ADDR_W_MAX-1:0] dest;
        logic                     mem_read;
    } sb_entry_t;

    function automatic int sel_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shift register of in-flight writebacks, entry 0 = EXE
module hazard_scoreboard
    import pipeline_ctrl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold,
    input  sb_entry_t             in_entry,
    output sb_entry_t [DEPTH-1:0] entries
);

    always_ff @(posedge clk) begin
        if (rst) begin
            entries <= '0;
        end else if (!hold) begin
            entries[0] <= in_entry;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - hazard detection, forwarding selects and stall statistics
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = sel_w(DEPTH)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_forwarding,
    input  logic                             id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    id_src_addr,
    input  logic [NUM_SRC-1:0]               id_src_used,
    input  logic                             id_wb_en,
    input  logic [REG_ADDR_W-1:0]            id_wb_dest,
    input  logic                             id_mem_read,
    input  logic                             branch_taken,
    input  logic                             mem_ready,
    input  logic                             stat_clr,
    output logic                             stall,
    output logic                             flush,
    output logic                             freeze,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic [CNT_W-1:0]                 stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_entry_t [DEPTH-1:0]           sb;
    sb_entry_t                       issue;
    logic [NUM_SRC-1:0][DEPTH-1:0]   match;
    logic                            hazard;

    hazard_scoreboard #(.DEPTH(DEPTH)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .hold     (freeze),
        .in_entry (issue),
        .entries  (sb)
    );

    always_comb begin
        match = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int k = 0; k < DEPTH; k++) begin
                match[s][k] = sb[k].valid & sb[k].wb_en & id_src_used[s] & id_valid &
                    (sb[k].dest == SB_ADDR_W_MAX'(id_src_addr[s*REG_ADDR_W +: REG_ADDR_W]));
            end
        end
    end

    // Scan from oldest to youngest so the youngest matching entry wins the select.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (en_forwarding) begin
                if (match[s][0] && sb[0].mem_read) begin
                    hazard = 1'b1;
                end
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (match[s][k]) begin
                        fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                    end
                end
            end else begin
                for (int k = 0; k < DEPTH - 1; k++) begin
                    if (match[s][k]) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign flush  = branch_taken;
    assign stall  = hazard & ~branch_taken;
    assign freeze = ~mem_ready;

    always_comb begin
        issue          = '0;
        issue.valid    = id_valid & ~stall & ~flush;
        issue.wb_en    = id_wb_en;
        issue.dest     = SB_ADDR_W_MAX'(id_wb_dest);
        issue.mem_read = id_mem_read;
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stall_count <= '0;
        end else if (stall && !freeze && stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table and directed sequences for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 3;
    localparam int NSRC  = 2;
    localparam int CW    = 4;
    localparam int SW    = 2;

    typedef struct {
        logic          rst, en, idv;
        logic [AW-1:0] s0, s1;
        logic [1:0]    used;
        logic          wb;
        logic [AW-1:0] dest;
        logic          mr, br, rdy, clr;
        logic          e_stall, e_flush, e_freeze;
        logic [SW-1:0] e_f0, e_f1;
        logic [CW-1:0] e_cnt;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en_forwarding = 1'b0;
    logic                 id_valid = 1'b0;
    logic [NSRC*AW-1:0]   id_src_addr = '0;
    logic [NSRC-1:0]      id_src_used = '0;
    logic                 id_wb_en = 1'b0;
    logic [AW-1:0]        id_wb_dest = '0;
    logic                 id_mem_read = 1'b0;
    logic                 branch_taken = 1'b0;
    logic                 mem_ready = 1'b1;
    logic                 stat_clr = 1'b0;
    logic                 stall, flush, freeze;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic [CW-1:0]        stall_count;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W(AW), .DEPTH(DEPTH), .NUM_SRC(NSRC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .en_forwarding(en_forwarding), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used), .id_wb_en(id_wb_en),
        .id_wb_dest(id_wb_dest), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .stat_clr(stat_clr), .stall(stall), .flush(flush),
        .freeze(freeze), .fwd_sel(fwd_sel), .stall_count(stall_count)
    );

    function automatic vec_t mk(
        input logic r, e, v, input logic [AW-1:0] a0, a1, input logic [1:0] u,
        input logic w, input logic [AW-1:0] d, input logic m, b, y, c,
        input logic xs, xf, xz, input logic [SW-1:0] x0, x1, input logic [CW-1:0] xc);
        vec_t t;
        t.rst = r; t.en = e; t.idv = v; t.s0 = a0; t.s1 = a1; t.used = u;
        t.wb = w; t.dest = d; t.mr = m; t.br = b; t.rdy = y; t.clr = c;
        t.e_stall = xs; t.e_flush = xf; t.e_freeze = xz;
        t.e_f0 = x0; t.e_f1 = x1; t.e_cnt = xc;
        return t;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        vec_t e;
        @(posedge clk);
        #1;
        rst = v.rst; en_forwarding = v.en; id_valid = v.idv;
        id_src_addr = {v.s1, v.s0}; id_src_used = v.used;
        id_wb_en = v.wb; id_wb_dest = v.dest; id_mem_read = v.mr;
        branch_taken = v.br; mem_ready = v.rdy; stat_clr = v.clr;
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check($sformatf("queue_empty[%0d]", idx), 1, 0);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("stall[%0d]", idx),  int'(stall),            int'(e.e_stall));
            check($sformatf("flush[%0d]", idx),  int'(flush),            int'(e.e_flush));
            check($sformatf("freeze[%0d]", idx), int'(freeze),           int'(e.e_freeze));
            check($sformatf("fwd0[%0d]", idx),   int'(fwd_sel[0 +: SW]), int'(e.e_f0));
            check($sformatf("fwd1[%0d]", idx),   int'(fwd_sel[SW +: SW]), int'(e.e_f1));
            check($sformatf("count[%0d]", idx),  int'(stall_count),      int'(e.e_cnt));
        end
    endtask

    initial begin
        int n;
        int c;
        // rst en idv s0 s1 used wb dest mr br rdy clr | stall flush freeze f0 f1 cnt
        tbl.push_back(mk(1,1,0, 0,0,0, 0,0, 0,1,1,0, 0,1,0, 0,0,0));  // reset, branch visible
        tbl.push_back(mk(0,1,1, 0,0,0, 1,2, 0,0,1,0, 0,0,0, 0,0,0));  // write r2
        tbl.push_back(mk(0,1,1, 2,0,1, 1,7, 0,0,1,0, 0,0,0, 1,0,0));  // read r2 from EXE
        tbl.push_back(mk(0,1,1, 2,7,3, 0,0, 0,0,1,0, 0,0,0, 2,1,0));  // r2 from MEM, r7 from EXE
        tbl.push_back(mk(0,1,1, 2,0,1, 0,0, 0,0,1,0, 0,0,0, 3,0,0));  // r2 from WB
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,0,1,0, 0,0,0, 0,0,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,3, 1,0,1,0, 0,0,0, 0,0,0));  // load r3
        tbl.push_back(mk(0,1,1, 0,3,2, 0,0, 0,0,1,0, 1,0,0, 0,1,0));  // load-use stall
        tbl.push_back(mk(0,1,1, 0,3,2, 0,0, 0,0,1,0, 0,0,0, 0,2,1));  // forward from MEM
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,0,1,0, 0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,1, 0,0,0, 1,5, 0,0,1,0, 0,0,0, 0,0,1));  // stall-only: write r5
        tbl.push_back(mk(0,0,1, 5,0,1, 0,0, 0,0,1,0, 1,0,0, 0,0,1));
        tbl.push_back(mk(0,0,1, 5,0,1, 0,0, 0,0,1,0, 1,0,0, 0,0,2));
        tbl.push_back(mk(0,0,1, 5,0,1, 0,0, 0,0,1,0, 0,0,0, 0,0,3));  // WB never stalls
        tbl.push_back(mk(0,1,1, 0,0,0, 1,4, 1,0,1,0, 0,0,0, 0,0,3));  // load r4
        tbl.push_back(mk(0,1,1, 4,0,1, 0,0, 0,1,1,0, 0,1,0, 1,0,3));  // branch beats hazard
        tbl.push_back(mk(0,1,1, 4,0,1, 0,0, 0,0,1,0, 0,0,0, 2,0,3));  // EXE is a bubble
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0,1,0, 0,0,0, 0,0, 0,0,1,0, 0,0,0, 0,0,3));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,6, 1,0,1,0, 0,0,0, 0,0,3));  // load r6
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,1,1, 6,0,1, 0,0, 0,0,0,0, 1,0,1, 1,0,3));  // frozen
        tbl.push_back(mk(0,1,1, 6,0,1, 0,0, 0,0,1,0, 1,0,0, 1,0,3));
        tbl.push_back(mk(0,1,1, 6,0,1, 0,0, 0,0,1,0, 0,0,0, 2,0,4));

        repeat (2) @(posedge clk);
        n = 0;
        foreach (tbl[i]) begin
            run_vec(tbl[i], n);
            n++;
        end

        // Saturation: ten writer/reader pairs in stall-only mode, two stall cycles each.
        run_vec(mk(0,0,0, 0,0,0, 0,0, 0,0,1,1, 0,0,0, 0,0,4), n++);
        c = 0;
        for (int i = 0; i < 10; i++) begin
            run_vec(mk(0,0,1, 0,0,0, 1,1, 0,0,1,0, 0,0,0, 0,0,CW'(c)), n++);
            run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,0, 1,0,0, 0,0,CW'(c)), n++);
            c = (c < 15) ? c + 1 : 15;
            run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,0, 1,0,0, 0,0,CW'(c)), n++);
            c = (c < 15) ? c + 1 : 15;
            run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,0, 0,0,0, 0,0,CW'(c)), n++);
        end
        // Clear wins over a simultaneous increment.
        run_vec(mk(0,0,1, 0,0,0, 1,1, 0,0,1,0, 0,0,0, 0,0,15), n++);
        run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,1, 1,0,0, 0,0,15), n++);
        run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,0, 1,0,0, 0,0,0), n++);
        run_vec(mk(0,0,1, 1,0,1, 0,0, 0,0,1,0, 0,0,0, 0,0,1), n++);
        // Reset during a stall empties the scoreboard and counter on that edge.
        run_vec(mk(0,0,1, 0,0,0, 1,9, 0,0,1,0, 0,0,0, 0,0,1), n++);
        run_vec(mk(1,0,1, 9,0,1, 0,0, 0,0,0,0, 1,0,1, 0,0,1), n++);
        run_vec(mk(0,0,1, 9,0,1, 0,0, 0,0,1,0, 0,0,0, 0,0,0), n++);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
